// File: rtl/mcs8_fetch_unit.sv
// MCS8 instruction front end: latency-tolerant byte prefetch, 1/2/3-byte instruction
// assembly, and redirect handling over a wrapping address stack.
module mcs8_fetch_unit #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned MEM_LAT     = 3,
    parameter int unsigned BUF_DEPTH   = 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    output logic [ADDR_W-1:0] I_ADDR_O,
    input  logic [7:0]        I_DAT_I,
    output logic              INS_VALID_O,
    input  logic              INS_READY_I,
    output logic [7:0]        INS_ICODE_O,
    output logic [7:0]        INS_B2_O,
    output logic [7:0]        INS_B3_O,
    output logic [1:0]        INS_LEN_O,
    output logic [ADDR_W-1:0] INS_VALP_O,
    input  logic              REDIR_I,
    input  logic [1:0]        REDIR_OP_I,
    input  logic [ADDR_W-1:0] REDIR_TGT_I,
    input  logic [ADDR_W-1:0] REDIR_RET_I,
    output logic              STK_OVF_O,
    output logic              STK_UNF_O
);
    localparam int unsigned SW = $clog2(STACK_DEPTH);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned QW = PW + 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + MEM_LAT + 1) + 1;

    typedef enum logic [1:0] {
        OpJump = 2'b00,
        OpCall = 2'b01,
        OpRet  = 2'b10,
        OpRst  = 2'b11
    } redirOpE;

    logic [ADDR_W-1:0] stackQ [STACK_DEPTH];
    logic [SW-1:0]     topQ;
    logic [SW-1:0]     liveQ;
    logic [MEM_LAT-1:0] pipeQ;
    logic [7:0]        queueQ [BUF_DEPTH];
    logic [PW-1:0]     rdPtrQ;
    logic [PW-1:0]     wrPtrQ;
    logic [QW-1:0]     countQ;
    logic [ADDR_W-1:0] headAddrQ;
    logic              ovfQ;
    logic              unfQ;

    redirOpE           op;
    logic [SW-1:0]     topInc;
    logic [SW-1:0]     topDec;
    logic [CW-1:0]     occupancy;
    logic [MEM_LAT-1:0] pipeD;
    logic              issue;
    logic              push;
    logic              valid;
    logic              accept;
    logic [7:0]        b1;
    logic [7:0]        b2;
    logic [7:0]        b3;
    logic [1:0]        len;
    logic [ADDR_W-1:0] redirAddr;

    assign op = redirOpE'(REDIR_OP_I);

    always_comb begin
        topInc = topQ + SW'(1);
        topDec = topQ - SW'(1);

        // Credit check counts every in-flight fetch, so a returning byte always has a slot.
        occupancy = CW'(countQ);
        for (int i = 0; i < MEM_LAT; i++) begin
            occupancy = occupancy + CW'(pipeQ[i]);
        end
        issue = !REDIR_I && (occupancy < CW'(BUF_DEPTH));
        push  = pipeQ[MEM_LAT-1] && !REDIR_I;
        pipeD = (pipeQ << 1) | MEM_LAT'(issue);

        b1 = queueQ[rdPtrQ];
        b2 = queueQ[rdPtrQ + PW'(1)];
        b3 = queueQ[rdPtrQ + PW'(2)];
        if (b1[7:6] == 2'b00 && b1[2] && !b1[0]) begin
            len = 2'd2;
        end else if (b1[7:6] == 2'b01 && !b1[0]) begin
            len = 2'd3;
        end else begin
            len = 2'd1;
        end
        valid  = countQ >= QW'(len);
        accept = valid && INS_READY_I;

        redirAddr = REDIR_TGT_I;
        case (op)
            OpJump, OpCall, OpRst: redirAddr = REDIR_TGT_I;
            OpRet:                 redirAddr = stackQ[topDec];
            default:               redirAddr = REDIR_TGT_I;
        endcase
    end

    always_comb begin
        I_ADDR_O    = stackQ[topQ];
        INS_VALID_O = valid;
        INS_ICODE_O = valid ? b1 : 8'h00;
        INS_B2_O    = (valid && len != 2'd1) ? b2 : 8'h00;
        INS_B3_O    = (valid && len == 2'd3) ? b3 : 8'h00;
        INS_LEN_O   = valid ? len : 2'd0;
        INS_VALP_O  = valid ? headAddrQ + ADDR_W'(len) : '0;
        STK_OVF_O   = ovfQ;
        STK_UNF_O   = unfQ;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stackQ[i] <= '0;
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                queueQ[i] <= '0;
            end
            topQ      <= '0;
            liveQ     <= '0;
            pipeQ     <= '0;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            countQ    <= '0;
            headAddrQ <= '0;
            ovfQ      <= 1'b0;
            unfQ      <= 1'b0;
        end else begin
            pipeQ <= REDIR_I ? '0 : pipeD;
            if (push) begin
                queueQ[wrPtrQ] <= I_DAT_I;
            end

            // A redirect flushes the queue even if an instruction is accepted this cycle.
            if (REDIR_I) begin
                rdPtrQ    <= '0;
                wrPtrQ    <= '0;
                countQ    <= '0;
                headAddrQ <= redirAddr;
            end else begin
                wrPtrQ <= wrPtrQ + PW'(push);
                rdPtrQ <= rdPtrQ + (accept ? PW'(len) : '0);
                countQ <= countQ + QW'(push) - (accept ? QW'(len) : '0);
                if (accept) begin
                    headAddrQ <= headAddrQ + ADDR_W'(len);
                end
            end

            if (REDIR_I) begin
                case (op)
                    OpJump: stackQ[topQ] <= REDIR_TGT_I;
                    OpCall, OpRst: begin
                        stackQ[topQ]   <= REDIR_RET_I;
                        stackQ[topInc] <= REDIR_TGT_I;
                        topQ           <= topInc;
                        if (liveQ == SW'(STACK_DEPTH - 1)) begin
                            ovfQ <= 1'b1;
                        end else begin
                            liveQ <= liveQ + SW'(1);
                        end
                    end
                    OpRet: begin
                        topQ <= topDec;
                        if (liveQ == '0) begin
                            unfQ <= 1'b1;
                        end else begin
                            liveQ <= liveQ - SW'(1);
                        end
                    end
                    default: stackQ[topQ] <= REDIR_TGT_I;
                endcase
            end else if (issue) begin
                stackQ[topQ] <= stackQ[topQ] + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mcs8_fetch_unit.sv
// Scoreboard bench for mcs8_fetch_unit: stimulus pushes expected instructions,
// a negedge monitor retires them on every accepted handshake.
module tb_mcs8_fetch_unit;
    localparam int ADDR_W = 14;
    localparam int MEM_LAT = 3;

    typedef struct {
        logic [7:0]        icode;
        logic [7:0]        b2;
        logic [7:0]        b3;
        logic [1:0]        len;
        logic [ADDR_W-1:0] valp;
    } insT;

    logic              CLK_I;
    logic              RST_I;
    logic [ADDR_W-1:0] I_ADDR_O;
    logic [7:0]        I_DAT_I;
    logic              INS_VALID_O;
    logic              INS_READY_I;
    logic [7:0]        INS_ICODE_O;
    logic [7:0]        INS_B2_O;
    logic [7:0]        INS_B3_O;
    logic [1:0]        INS_LEN_O;
    logic [ADDR_W-1:0] INS_VALP_O;
    logic              REDIR_I;
    logic [1:0]        REDIR_OP_I;
    logic [ADDR_W-1:0] REDIR_TGT_I;
    logic [ADDR_W-1:0] REDIR_RET_I;
    logic              STK_OVF_O;
    logic              STK_UNF_O;

    logic [7:0]        rom [16384];
    logic [ADDR_W-1:0] addrPipe [MEM_LAT];
    insT               expQ [$];
    int                nCmp = 0;
    int                nErr = 0;

    mcs8_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (8),
        .MEM_LAT     (MEM_LAT),
        .BUF_DEPTH   (8)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .I_ADDR_O    (I_ADDR_O),
        .I_DAT_I     (I_DAT_I),
        .INS_VALID_O (INS_VALID_O),
        .INS_READY_I (INS_READY_I),
        .INS_ICODE_O (INS_ICODE_O),
        .INS_B2_O    (INS_B2_O),
        .INS_B3_O    (INS_B3_O),
        .INS_LEN_O   (INS_LEN_O),
        .INS_VALP_O  (INS_VALP_O),
        .REDIR_I     (REDIR_I),
        .REDIR_OP_I  (REDIR_OP_I),
        .REDIR_TGT_I (REDIR_TGT_I),
        .REDIR_RET_I (REDIR_RET_I),
        .STK_OVF_O   (STK_OVF_O),
        .STK_UNF_O   (STK_UNF_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // ICode memory: data appears MEM_LAT cycles after its address.
    always @(posedge CLK_I) begin
        addrPipe[0] <= I_ADDR_O;
        for (int i = 1; i < MEM_LAT; i++) begin
            addrPipe[i] <= addrPipe[i-1];
        end
    end
    assign I_DAT_I = rom[addrPipe[MEM_LAT-1]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic atMid();
        @(negedge CLK_I);
    endtask

    // Expected 1-byte instructions starting at a hand-filled 1-byte region.
    task automatic pushSeq(input logic [ADDR_W-1:0] start, input int n);
        insT e;
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            a       = start + ADDR_W'(i);
            e.icode = rom[a];
            e.b2    = 8'h00;
            e.b3    = 8'h00;
            e.len   = 2'd1;
            e.valp  = a + ADDR_W'(1);
            expQ.push_back(e);
        end
    endtask

    task automatic pushIns(input logic [7:0] ic, input logic [7:0] x2, input logic [7:0] x3,
                           input logic [1:0] ln, input logic [ADDR_W-1:0] vp);
        insT e;
        e.icode = ic;
        e.b2    = x2;
        e.b3    = x3;
        e.len   = ln;
        e.valp  = vp;
        expQ.push_back(e);
    endtask

    // Strobe a redirect in the current cycle; returns at the start of cycle r+1.
    task automatic redirect(input logic [1:0] op, input logic [ADDR_W-1:0] tgt,
                            input logic [ADDR_W-1:0] ret);
        REDIR_I     = 1'b1;
        REDIR_OP_I  = op;
        REDIR_TGT_I = tgt;
        REDIR_RET_I = ret;
        atMid();
        nextCycle();
        REDIR_I = 1'b0;
        expQ.delete();
    endtask

    task automatic refill(input logic [ADDR_W-1:0] addr, input int fv);
        for (int k = 1; k <= fv; k++) begin
            atMid();
            if (k == 1) chk("redir_addr", I_ADDR_O, addr);
            chk("refill_valid", INS_VALID_O, k == fv);
            nextCycle();
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) nextCycle();
    endtask

    // Checks the post-reset start-up: address ramp and first VALID in cycle MEM_LAT+1.
    task automatic startup(input int n);
        for (int c = 0; c < n; c++) begin
            atMid();
            chk("addr_stream", I_ADDR_O, c);
            chk("valid_latency", INS_VALID_O, c >= MEM_LAT + 1);
            if (c == 0) begin
                chk("rst_icode", INS_ICODE_O, 0);
                chk("rst_len", INS_LEN_O, 0);
                chk("rst_valp", INS_VALP_O, 0);
                chk("rst_b2b3", {INS_B2_O, INS_B3_O}, 0);
                chk("rst_flags", {STK_OVF_O, STK_UNF_O}, 0);
            end
            nextCycle();
        end
    endtask

    always @(negedge CLK_I) begin
        if (!RST_I && INS_VALID_O && INS_READY_I) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_ins: got icode 0x%0h valp 0x%0h, want none",
                         INS_ICODE_O, INS_VALP_O);
            end else begin
                insT e;
                e = expQ.pop_front();
                chk("ins_icode", INS_ICODE_O, e.icode);
                chk("ins_b2", INS_B2_O, e.b2);
                chk("ins_b3", INS_B3_O, e.b3);
                chk("ins_len", INS_LEN_O, e.len);
                chk("ins_valp", INS_VALP_O, e.valp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 16384; a++) rom[a] = {1'b1, 7'(a)};
        rom[0] = 8'h00;
        rom[1] = 8'h01;
        rom[2] = 8'h02;
        rom[3] = 8'h03;
        rom[14'h040] = 8'h06;
        rom[14'h041] = 8'h5A;
        rom[14'h042] = 8'h44;
        rom[14'h043] = 8'h34;
        rom[14'h044] = 8'h12;

        RST_I       = 1'b1;
        INS_READY_I = 1'b1;
        REDIR_I     = 1'b0;
        REDIR_OP_I  = 2'b00;
        REDIR_TGT_I = '0;
        REDIR_RET_I = '0;
        runCycles(3);

        // Streaming start-up
        RST_I = 1'b0;
        pushSeq(14'h0000, 40);
        startup(12);

        // Back-pressure: issue stops at 8 bytes of occupancy, head holds
        INS_READY_I = 1'b0;
        for (int c = 0; c < 20; c++) begin
            atMid();
            chk("stall_valid", INS_VALID_O, 1);
            chk("stall_icode", INS_ICODE_O, expQ[0].icode);
            if (c >= 8) chk("stall_addr", I_ADDR_O, 16);
            nextCycle();
        end
        INS_READY_I = 1'b1;
        runCycles(20);
        chk("drain_count", expQ.size(), 12);

        // Jump, taken while a handshake is also accepted
        redirect(2'b00, 14'h0100, 14'h0000);
        pushSeq(14'h0100, 20);
        refill(14'h0100, 5);
        runCycles(6);

        // Multi-byte instructions
        redirect(2'b00, 14'h0040, 14'h0000);
        pushIns(8'h06, 8'h5A, 8'h00, 2'd2, 14'h0042);
        pushIns(8'h44, 8'h34, 8'h12, 2'd3, 14'h0045);
        pushSeq(14'h0045, 10);
        refill(14'h0040, 6);
        runCycles(8);
        chk("multi_retired", (expQ.size() < 10), 1);

        // Call then return
        redirect(2'b01, 14'h0200, 14'h0010);
        pushSeq(14'h0200, 20);
        refill(14'h0200, 5);
        runCycles(6);
        redirect(2'b10, 14'h0000, 14'h0000);
        pushSeq(14'h0010, 20);
        refill(14'h0010, 5);
        runCycles(6);
        chk("callret_flags", {STK_OVF_O, STK_UNF_O}, 0);

        // Reset while fetches are in flight
        RST_I = 1'b1;
        expQ.delete();
        nextCycle();
        RST_I = 1'b0;
        pushSeq(14'h0000, 20);
        startup(6);
        runCycles(4);

        // Stack overflow / underflow with decode stalled
        INS_READY_I = 1'b0;
        runCycles(2);
        for (int i = 1; i <= 8; i++) begin
            redirect(2'b01, ADDR_W'(14'h1000 + i * 16), ADDR_W'(14'h0800 + i));
            atMid();
            chk("call_addr", I_ADDR_O, 14'h1000 + i * 16);
            chk("call_ovf", STK_OVF_O, i == 8);
            nextCycle();
            nextCycle();
        end
        for (int j = 1; j <= 9; j++) begin
            redirect(2'b10, 14'h0000, 14'h0000);
            atMid();
            if (j <= 7) chk("ret_addr", I_ADDR_O, 14'h0800 + (9 - j));
            chk("ret_unf", STK_UNF_O, j >= 8);
            chk("ret_ovf_sticky", STK_OVF_O, 1);
            nextCycle();
            nextCycle();
        end
        RST_I = 1'b1;
        nextCycle();
        RST_I = 1'b0;
        atMid();
        chk("flags_cleared", {STK_OVF_O, STK_UNF_O}, 0);
        chk("rst_addr", I_ADDR_O, 0);
        chk("rst_valid", INS_VALID_O, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
